unpacked_array_serializer: RTL and testbench

Downstream width-converter stage for unpacked register-slice outputs. It captures one IN_SIZE-element unpacked vector under a valid/ready handshake and re-emits it as IN_SIZE/OUT_SIZE consecutive OUT_SIZE-element beats, lowest-index elements first, with a last-beat marker. It lets a wide datapath stage feed a narrower compute or streaming stage without stalls between vectors.

---
 rtl/unpacked_array_serializer_if.sv | 27 ++
 rtl/unpacked_array_serializer.sv | 67 ++++++
 tb/tb_unpacked_array_serializer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unpacked_array_serializer_if.sv
// Stream bundle for the serializer: a wide unpacked input vector in, narrow
// unpacked beats out. The DUT takes the slave side; the producer/consumer pair takes master.
interface unpacked_array_serializer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_SIZE    = 16,
    parameter int OUT_SIZE   = 4
);
    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high. Valid never depends on ready. ready may depend combinationally on the far side.
    logic [DATA_WIDTH-1:0] in_data [IN_SIZE];
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data [OUT_SIZE];
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/unpacked_array_serializer.sv
// Captures one IN_SIZE-element vector and replays it as IN_SIZE/OUT_SIZE beats,
// lowest elements first, reloading on the last beat so vectors stream without bubbles.
module unpacked_array_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_SIZE    = 16,
    parameter int OUT_SIZE   = 4
) (
    input  logic clk,
    input  logic rst,
    unpacked_array_serializer_if.slave bus,
    output logic dbg_state
);
    localparam int BEATS = IN_SIZE / OUT_SIZE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

    if (IN_SIZE % OUT_SIZE != 0) begin : g_bad_ratio
        $error("IN_SIZE must be a multiple of OUT_SIZE");
    end

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] buffer [IN_SIZE];
    logic [DATA_WIDTH-1:0] beat [OUT_SIZE];
    logic [IW-1:0]         base;
    logic                  last_beat;
    logic                  in_fire;
    logic                  out_fire;

    assign last_beat     = (cnt == CW'(BEATS - 1));
    assign bus.out_valid = (state == SEND);
    assign bus.out_last  = bus.out_valid && last_beat;
    assign out_fire      = bus.out_valid && bus.out_ready;
    // Accept only when empty, or when the final beat leaves on this very edge.
    assign bus.in_ready  = !rst && (!bus.out_valid || (out_fire && last_beat));
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign dbg_state     = state;

    always_comb begin
        base = IW'(int'(cnt) * OUT_SIZE);
        for (int j = 0; j < OUT_SIZE; j++) begin
            beat[j] = buffer[base + IW'(j)];
        end
    end

    assign bus.out_data = beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (in_fire) begin
            buffer <= bus.in_data;
            cnt    <= '0;
            state  <= SEND;
        end else if (out_fire) begin
            if (last_beat) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Bench for unpacked_array_serializer: a 16->4 instance and a 4->4 (single-beat)
// instance, checked by directed cycle checks plus an expected-beat queue per instance.
module tb_unpacked_array_serializer;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int W  = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_state;
    logic dbg_state1;

    int n_vec   = 0;
    int n_err   = 0;
    int n_in    = 0;
    int n_last  = 0;
    int n_in1   = 0;
    int n_last1 = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp1_q[$];
    logic [W-1:0] bp_exp;

    unpacked_array_serializer_if #(.DATA_WIDTH(DW), .IN_SIZE(16), .OUT_SIZE(4)) bus ();
    unpacked_array_serializer_if #(.DATA_WIDTH(DW), .IN_SIZE(4), .OUT_SIZE(4)) bus1 ();

    unpacked_array_serializer #(.DATA_WIDTH(DW), .IN_SIZE(16), .OUT_SIZE(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    unpacked_array_serializer #(.DATA_WIDTH(DW), .IN_SIZE(4), .OUT_SIZE(4)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg_state1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_main(input int base);
        for (int i = 0; i < 16; i++) bus.in_data[i] = DW'(base + i);
    endtask

    task automatic set_small(input int base);
        for (int i = 0; i < 4; i++) bus1.in_data[i] = DW'(base + i);
    endtask

    function automatic logic [W-1:0] out_main();
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) v[j*DW +: DW] = bus.out_data[j];
        v[128] = bus.out_last;
        return v;
    endfunction

    function automatic logic [W-1:0] out_small();
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) v[j*DW +: DW] = bus1.out_data[j];
        v[128] = bus1.out_last;
        return v;
    endfunction

    // Monitor: pop on each output transfer, push the model's beats on each input transfer.
    always @(negedge clk) begin
        logic [W-1:0] v;
        if (rst) begin
            exp_q.delete();
            exp1_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check("main_q_nonempty", W'(exp_q.size() != 0), W'(1));
                if (exp_q.size() != 0) check("main_beat", out_main(), exp_q.pop_front());
                if (bus.out_last) n_last++;
            end
            if (bus.in_valid && bus.in_ready) begin
                n_in++;
                for (int b = 0; b < MB; b++) begin
                    v = '0;
                    for (int j = 0; j < 4; j++) v[j*DW +: DW] = bus.in_data[b*4 + j];
                    v[128] = (b == MB - 1);
                    exp_q.push_back(v);
                end
            end
            if (bus1.out_valid && bus1.out_ready) begin
                check("small_q_nonempty", W'(exp1_q.size() != 0), W'(1));
                if (exp1_q.size() != 0) check("small_beat", out_small(), exp1_q.pop_front());
                if (bus1.out_last) n_last1++;
            end
            if (bus1.in_valid && bus1.in_ready) begin
                n_in1++;
                v = '0;
                for (int j = 0; j < 4; j++) v[j*DW +: DW] = bus1.in_data[j];
                v[128] = 1'b1;
                exp1_q.push_back(v);
            end
        end
    end

    initial begin
        void'($urandom(32'd20240611));
        bp_exp = '0;
        for (int j = 0; j < 4; j++) bp_exp[j*DW +: DW] = DW'(4 + j);
        set_main(0);
        set_small(0);
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_out_last", W'(bus.out_last), W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(0));
        check("rst_state", W'(dbg_state), W'(0));
        check("rst_small_in_ready", W'(bus1.in_ready), W'(0));
        check("rst_small_out_valid", W'(bus1.out_valid), W'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", W'(bus.in_ready), W'(1));
        check("rel_small_in_ready", W'(bus1.in_ready), W'(1));

        // Single vector, beats follow one cycle after acceptance
        step();
        set_main(0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t1_latency_valid", W'(bus.out_valid), W'(1));
        check("t1_cnt0", W'(u_dut.cnt), W'(0));
        check("t1_state_send", W'(dbg_state), W'(1));
        repeat (4) @(negedge clk);
        check("t1_idle", W'(bus.out_valid), W'(0));
        check("t1_drained", W'(exp_q.size()), W'(0));

        // Back-to-back vectors: no gap, in_ready only in idle and last-beat cycles
        step();
        set_main(0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("b2b_in_ready_%0d", k), W'(bus.in_ready), W'(k == 0 || k == 4 || k == 8));
            check($sformatf("b2b_out_valid_%0d", k), W'(bus.out_valid), W'(k >= 1));
            step();
            if (k == 0) set_main(32'h100);
            if (k == 4) bus.in_valid = 1'b0;
        end

        // Backpressure on beat 1
        set_main(0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check("bp_data", out_main(), bp_exp);
            check("bp_cnt", W'(u_dut.cnt), W'(1));
            check("bp_in_ready", W'(bus.in_ready), W'(0));
            check("bp_valid", W'(bus.out_valid), W'(1));
            step();
        end
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_idle", W'(bus.out_valid), W'(0));
        check("bp_drained", W'(exp_q.size()), W'(0));
        step();

        // Reset after beat 1 fires discards the rest of the vector
        set_main(32'h300);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("midrst_valid", W'(bus.out_valid), W'(0));
        check("midrst_last", W'(bus.out_last), W'(0));
        step();
        rst = 1'b0;
        set_main(32'h400);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_c_drained", W'(exp_q.size()), W'(0));
        check("midrst_c_idle", W'(bus.out_valid), W'(0));
        step();

        // Single-beat configuration at full throughput
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_small(32'h500 + 16 * k);
            bus1.in_valid = 1'b1;
            @(negedge clk);
            check("s_in_ready", W'(bus1.in_ready), W'(1));
            check("s_valid", W'(bus1.out_valid), W'(k >= 1));
            check("s_last", W'(bus1.out_last), W'(k >= 1));
            step();
        end
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("s_final_valid", W'(bus1.out_valid), W'(1));
        step();
        @(negedge clk);
        check("s_idle", W'(bus1.out_valid), W'(0));
        check("s_drained", W'(exp1_q.size()), W'(0));
        step();

        // Random valid/ready on both instances
        n_in = 0;
        n_last = 0;
        n_in1 = 0;
        n_last1 = 0;
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            bus1.in_valid  = 1'($urandom_range(0, 1));
            bus1.out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 16; i++) bus.in_data[i] = $urandom();
            for (int i = 0; i < 4; i++) bus1.in_data[i] = $urandom();
            step();
        end
        bus.in_valid   = 1'b0;
        bus1.in_valid  = 1'b0;
        bus.out_ready  = 1'b1;
        bus1.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rand_in_fired", W'(n_in > 0), W'(1));
        check("rand_last_count", W'(n_last), W'(n_in));
        check("rand_drained", W'(exp_q.size()), W'(0));
        check("rand_small_last_count", W'(n_last1), W'(n_in1));
        check("rand_small_drained", W'(exp1_q.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
